// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout, FSM states and the default queue depth live here.
package fetch_pkg;

    localparam int FQ_DEFAULT_DEPTH = 4;
    localparam int FQ_XLEN          = 32;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
        logic               fault;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle: memory return, redirect, PC stall and decode handshake.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int XLEN  = FQ_XLEN
);
    logic                     in_valid;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_instr;
    logic                     flush;
    logic                     stall_o;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_instr;
    logic                     out_fault;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  stall_o, out_valid, out_pc, out_instr, out_fault, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output stall_o, out_valid, out_pc, out_instr, out_fault, count
    );
endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x fetch_entry_t, registered write, combinational read.
// Latency: written data readable the cycle after the write edge; no backpressure.
// Backpressure: none; the caller owns pointer and occupancy control.
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FQ_DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_entry_t  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fetch_entry_t  rdata_o
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} from imem and hands them to decode.
// Latency: 1 cycle push-to-head (no empty bypass); stall_o rises once count >= DEPTH-1.
// Backpressure: valid/ready to decode; flush kills wrong path. Option: FETCH_QUEUE_MISALIGN_CHECK_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave fq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fq_state_t     state_q, state_d;

    logic          empty, full, push, pop, wr_en;
    fetch_entry_t  wr_entry, head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = fq.in_valid && (state_q == RUN) && !fq.flush;
    assign pop   = !empty && fq.out_ready && !fq.flush;
    // A full queue can still take a word when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = FQ_XLEN'(fq.in_pc);
        wr_entry.instr = FQ_XLEN'(fq.in_instr);
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
        wr_entry.fault = pc_misaligned(fq.in_pc[1:0]);
`endif
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // The word returned in the cycle after a redirect is wrong-path, hence KILL.
    always_comb begin
        state_d = state_q;
        if (fq.flush) begin
            state_d = KILL;
        end else if (state_q == KILL) begin
            state_d = RUN;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    assign fq.out_valid = !empty;
    assign fq.out_pc    = empty ? '0 : head.pc[XLEN-1:0];
    assign fq.out_instr = empty ? '0 : head.instr[XLEN-1:0];
    assign fq.stall_o   = (count_q >= CW'(DEPTH - 1));
    assign fq.count     = count_q;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
    assign fq.out_fault = !empty && head.fault;
`else
    logic unused_fault;
    assign unused_fault = head.fault;
    assign fq.out_fault = 1'b0;
`endif

    // Fetch must honour stall_o; a push into a full queue without a pop is dropped.
    overflow_dropped: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle plus literal pins.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk;
    logic rst;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of queued words plus a "drop next word" flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ment_t;

    ment_t mq[$];
    bit    mkill;
    int    m_n;
    bit    m_pop, m_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mkill = 1'b0;
        end else if (fq.flush) begin
            mq.delete();
            mkill = 1'b1;
        end else begin
            m_n    = mq.size();
            m_pop  = (m_n != 0) && fq.out_ready;
            m_push = fq.in_valid && !mkill;
            if (m_pop) void'(mq.pop_front());
            if (m_push && (m_n < DEPTH || m_pop)) mq.push_back('{fq.in_pc, fq.in_instr});
            mkill = 1'b0;
        end
    end

    logic [31:0] e_pc, e_instr;
    logic        e_fault;

    always @(negedge clk) begin
        if (!rst) begin
            e_pc    = 32'h0;
            e_instr = 32'h0;
            e_fault = 1'b0;
            if (mq.size() != 0) begin
                e_pc    = mq[0].pc;
                e_instr = mq[0].instr;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
                e_fault = (e_pc[1:0] != 2'b00);
`endif
            end
            chk("m_valid", 32'(fq.out_valid), 32'(mq.size() != 0));
            chk("m_pc",    fq.out_pc,    e_pc);
            chk("m_instr", fq.out_instr, e_instr);
            chk("m_fault", 32'(fq.out_fault), 32'(e_fault));
            chk("m_count", 32'(fq.count), 32'(mq.size()));
            chk("m_stall", 32'(fq.stall_o), 32'(mq.size() >= DEPTH - 1));
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc);
        fq.in_valid = v;
        fq.in_pc    = pc;
        fq.in_instr = pc ^ 32'hA5A5_0013;
    endtask

    localparam logic EXP_FAULT_MIS =
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        rst          = 1'b1;
        fq.flush     = 1'b0;
        fq.out_ready = 1'b0;
        drive(1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(fq.out_valid), 32'd0);
        chk("rst_count", 32'(fq.count), 32'd0);
        chk("rst_stall", 32'(fq.stall_o), 32'd0);
        chk("rst_pc",    fq.out_pc, 32'h0);
        chk("rst_fault", 32'(fq.out_fault), 32'd0);
        rst = 1'b0;

        // Fill to DEPTH-1, then the in-flight fourth word.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4));
            @(negedge clk);
        end
        chk("fill_count", 32'(fq.count), 32'd3);
        chk("fill_stall", 32'(fq.stall_o), 32'd1);
        chk("fill_head",  fq.out_pc, 32'h0);
        drive(1'b1, 32'hC);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("full_count", 32'(fq.count), 32'd4);
        chk("full_head",  fq.out_pc, 32'h0);

        // Drain in order.
        fq.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("drain_pc", fq.out_pc, 32'(i * 4));
        end
        @(negedge clk);
        chk("drain_valid", 32'(fq.out_valid), 32'd0);
        chk("drain_stall", 32'(fq.stall_o), 32'd0);

        // Push and pop together across two pointer wraps.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4));
            @(negedge clk);
            chk("wrap_count", 32'(fq.count), 32'd1);
            chk("wrap_pc",    fq.out_pc, 32'h100 + 32'(i * 4));
        end
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("wrap_empty", 32'(fq.out_valid), 32'd0);

        // Flush with three queued words and wrong-path returns.
        fq.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40 + 32'(i * 4));
            @(negedge clk);
        end
        chk("pre_flush_count", 32'(fq.count), 32'd3);
        fq.flush = 1'b1;
        fq.out_ready = 1'b1;
        drive(1'b1, 32'h20);
        @(negedge clk);
        chk("flush_n1_valid", 32'(fq.out_valid), 32'd0);
        fq.flush = 1'b0;
        fq.out_ready = 1'b0;
        drive(1'b1, 32'h24);
        @(negedge clk);
        chk("flush_n2_valid", 32'(fq.out_valid), 32'd0);
        drive(1'b1, 32'h80);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("flush_target_pc", fq.out_pc, 32'h80);
        chk("flush_target_cnt", 32'(fq.count), 32'd1);
        fq.out_ready = 1'b1;
        @(negedge clk);
        fq.out_ready = 1'b0;

        // Back-to-back flush extends the kill window by one cycle.
        fq.flush = 1'b1;
        drive(1'b1, 32'h88);
        @(negedge clk);
        drive(1'b1, 32'h8C);
        @(negedge clk);
        fq.flush = 1'b0;
        drive(1'b1, 32'h90);
        @(negedge clk);
        drive(1'b1, 32'h94);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("kill2_pc",    fq.out_pc, 32'h94);
        chk("kill2_count", 32'(fq.count), 32'd1);
        fq.out_ready = 1'b1;
        @(negedge clk);
        fq.out_ready = 1'b0;

        // Reset mid-run overrides flush and push.
        drive(1'b1, 32'h200);
        @(negedge clk);
        drive(1'b1, 32'h204);
        @(negedge clk);
        chk("mid_pre_count", 32'(fq.count), 32'd2);
        rst = 1'b1;
        fq.flush = 1'b1;
        drive(1'b1, 32'h300);
        @(negedge clk);
        chk("mid_rst_count", 32'(fq.count), 32'd0);
        chk("mid_rst_valid", 32'(fq.out_valid), 32'd0);
        chk("mid_rst_pc",    fq.out_pc, 32'h0);
        chk("mid_rst_stall", 32'(fq.stall_o), 32'd0);
        rst = 1'b0;
        fq.flush = 1'b0;
        drive(1'b1, 32'h208);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("post_rst_pc",    fq.out_pc, 32'h208);
        chk("post_rst_count", 32'(fq.count), 32'd1);
        fq.out_ready = 1'b1;
        @(negedge clk);
        fq.out_ready = 1'b0;

        // Misaligned pc flag.
        drive(1'b1, 32'h6);
        @(negedge clk);
        drive(1'b1, 32'h8);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("fault_mis", 32'(fq.out_fault), 32'(EXP_FAULT_MIS));
        chk("fault_mis_pc", fq.out_pc, 32'h6);
        fq.out_ready = 1'b1;
        @(negedge clk);
        chk("fault_ok", 32'(fq.out_fault), 32'd0);
        chk("fault_ok_pc", fq.out_pc, 32'h8);
        @(negedge clk);
        fq.out_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
